// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per cycle with first/last frame markers.
module shift_reg_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_first,
    output logic             sdo_last
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             sdo_d, sdo_valid_d, sdo_first_d, sdo_last_d;
    logic             last_bit, accept;

    // The last-bit cycle doubles as the acceptance window for the next word.
    assign last_bit  = (state == SHIFT) && (cnt == LAST);
    assign din_ready = (state == IDLE) || last_bit;
    assign accept    = din_valid && din_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state;
        cnt_d       = cnt;
        shreg_d     = shreg;
        sdo_d       = sdo;
        sdo_valid_d = sdo_valid;
        sdo_first_d = sdo_first;
        sdo_last_d  = sdo_last;

        if (accept) begin
            // Bit 0 goes straight to the sdo register; the rest waits in shreg.
            state_d     = SHIFT;
            cnt_d       = '0;
            shreg_d     = MSB_FIRST ? (din << 1) : (din >> 1);
            sdo_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
            sdo_valid_d = 1'b1;
            sdo_first_d = 1'b1;
            sdo_last_d  = (WIDTH == 1);
        end else if (state == IDLE || last_bit) begin
            state_d     = IDLE;
            cnt_d       = '0;
            shreg_d     = '0;
            sdo_d       = 1'b0;
            sdo_valid_d = 1'b0;
            sdo_first_d = 1'b0;
            sdo_last_d  = 1'b0;
        end else begin
            cnt_d       = cnt + 1'b1;
            shreg_d     = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            sdo_d       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            sdo_valid_d = 1'b1;
            sdo_first_d = 1'b0;
            sdo_last_d  = (cnt_d == LAST);
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            sdo_first <= 1'b0;
            sdo_last  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            shreg     <= shreg_d;
            sdo       <= sdo_d;
            sdo_valid <= sdo_valid_d;
            sdo_first <= sdo_first_d;
            sdo_last  <= sdo_last_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Scoreboard bench for shift_reg_piso_tx: three configurations (8/MSB, 8/LSB, 1-bit),
// expected bits queued at each handshake and compared every cycle on the falling edge.
module tb_shift_reg_piso_tx;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         sel       = 0;
    logic       mon_on    = 1'b0;

    logic [7:0] din_m, din_l;
    logic [0:0] din_1;
    logic       v_m, v_l, v_1;
    logic       r_m, r_l, r_1;
    logic       s_m, s_l, s_1;
    logic       sv_m, sv_l, sv_1;
    logic       sf_m, sf_l, sf_1;
    logic       sl_m, sl_l, sl_1;

    logic       m_rdy, m_sdo, m_sv, m_sf, m_sl;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .din(din_m), .din_valid(v_m), .din_ready(r_m),
        .sdo(s_m), .sdo_valid(sv_m), .sdo_first(sf_m), .sdo_last(sl_m));

    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .din(din_l), .din_valid(v_l), .din_ready(r_l),
        .sdo(s_l), .sdo_valid(sv_l), .sdo_first(sf_l), .sdo_last(sl_l));

    shift_reg_piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_one (
        .clk(clk), .reset_n(reset_n), .din(din_1), .din_valid(v_1), .din_ready(r_1),
        .sdo(s_1), .sdo_valid(sv_1), .sdo_first(sf_1), .sdo_last(sl_1));

    always_comb begin
        m_rdy = r_m; m_sdo = s_m; m_sv = sv_m; m_sf = sf_m; m_sl = sl_m;
        case (sel)
            1: begin m_rdy = r_l; m_sdo = s_l; m_sv = sv_l; m_sf = sf_l; m_sl = sl_l; end
            2: begin m_rdy = r_1; m_sdo = s_1; m_sv = sv_1; m_sf = sf_1; m_sl = sl_1; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_all();
        check("rst_out_msb", 32'({sv_m, s_m, sf_m, sl_m}), 32'd0);
        check("rst_rdy_msb", 32'(r_m), 32'd1);
        check("rst_out_lsb", 32'({sv_l, s_l, sf_l, sl_l}), 32'd0);
        check("rst_rdy_lsb", 32'(r_l), 32'd1);
        check("rst_out_one", 32'({sv_1, s_1, sf_1, sl_1}), 32'd0);
        check("rst_rdy_one", 32'(r_1), 32'd1);
    endtask

    // Every cycle: either the next queued bit is on the wire, or the block is idle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ready_busy", 32'(m_rdy), 32'(e.last));
                check("valid", 32'(m_sv), 32'd1);
                check("bit_first_last", 32'({m_sdo, m_sf, m_sl}), 32'(e));
            end else begin
                check("ready_idle", 32'(m_rdy), 32'd1);
                check("idle_out", 32'({m_sv, m_sdo, m_sf, m_sl}), 32'd0);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the handshake.
    task automatic send(input logic [7:0] w);
        int n     = 0;
        int width = (sel == 2) ? 1 : 8;
        bit msb   = (sel != 1);
        exp_t x;
        case (sel)
            1:       begin din_l = w;    v_l = 1'b1; end
            2:       begin din_1 = w[0]; v_1 = 1'b1; end
            default: begin din_m = w;    v_m = 1'b1; end
        endcase
        while (!m_rdy && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            for (int i = 0; i < width; i++) begin
                x.b     = msb ? w[width-1-i] : w[i];
                x.first = (i == 0);
                x.last  = (i == width - 1);
                q.push_back(x);
            end
            @(negedge clk);
        end
        v_m = 1'b0; v_l = 1'b0; v_1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        din_m = '0; din_l = '0; din_1 = '0;
        v_m = 1'b0; v_l = 1'b0; v_1 = 1'b0;
        #1 reset_n = 1'b0;
        // Reset before the first rising edge, then with the clock running and random inputs.
        repeat (4) begin
            din_m = 8'($urandom); din_l = 8'($urandom); din_1 = 1'($urandom);
            v_m = 1'($urandom); v_l = 1'($urandom); v_1 = 1'($urandom);
            #1 check_reset_all();
            @(negedge clk);
        end
        v_m = 1'b0; v_l = 1'b0; v_1 = 1'b0;
        reset_n = 1'b1;
        mon_on  = 1'b1;
        idle(2);

        sel = 0;
        send(8'hA5);
        idle(10);

        send(8'hA5);
        send(8'h3C);
        idle(12);

        // The second word is offered throughout the first frame and must wait.
        send(8'hA5);
        send(8'hFF);
        idle(12);

        send(8'h5A);
        repeat (5) begin
            din_m = 8'($urandom);
            @(negedge clk);
        end
        idle(6);

        sel = 1;
        send(8'h01);
        send(8'hC3);
        idle(12);

        sel = 2;
        send(8'h01);
        send(8'h00);
        send(8'h01);
        idle(3);

        // Abort a frame after bit 2 with an asynchronous reset between clock edges.
        sel = 0;
        send(8'hA5);
        @(negedge clk);
        @(negedge clk);
        #2;
        mon_on  = 1'b0;
        reset_n = 1'b0;
        #1 check_reset_all();
        q.delete();
        repeat (3) begin
            @(negedge clk);
            check_reset_all();
        end
        reset_n = 1'b1;
        mon_on  = 1'b1;
        send(8'h5A);
        idle(12);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_reg_piso_tx.md
SHIFT_REG_PISO_TX -- requirements
Module: shift_reg_piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per serial frame; legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = transmit din[WIDTH-1] first, 0 = transmit din[0] first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  source has a word on din.
REQ-007 din_ready  output  1  block accepts a word this cycle.
REQ-008 sdo  output  1  serial data out.
REQ-009 sdo_valid  output  1  sdo carries a frame bit this cycle.
REQ-010 sdo_first  output  1  high with the first bit of each frame.
REQ-011 sdo_last  output  1  high with the last bit of each frame.

Function
REQ-012 Block shall implement two states: IDLE (no frame in progress) and SHIFT (frame in progress).
REQ-013 Handshake shall complete on a rising edge where din_valid=1 and din_ready=1; din shall be captured into an internal shift register at that edge only.
REQ-014 din_ready shall be 1 in IDLE, 1 in SHIFT during the last-bit cycle, and 0 in all other SHIFT cycles; din_ready shall be a function of state and bit counter only, never of din_valid.
REQ-015 din_valid while din_ready=0 shall be ignored; no data captured, no state change.
REQ-016 Handshake at edge k: bit i of the frame (i = 0..WIDTH-1) shall be driven on sdo with sdo_valid=1 in the cycle following edge k+i; latency from handshake to first bit is one cycle.
REQ-017 Bit order: MSB_FIRST=1 sends din[WIDTH-1] down to din[0]; MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
REQ-018 sdo_first shall be 1 only with bit 0; sdo_last shall be 1 only with bit WIDTH-1; for WIDTH=1 both shall be 1 in the single bit cycle.
REQ-019 An internal bit counter of width max(1,clog2(WIDTH)) shall count 0..WIDTH-1 and clear on each new frame; it shall never wrap mid-frame.
REQ-020 Handshake during the last-bit cycle shall start the next frame in the immediately following cycle (zero-gap back-to-back); sdo_valid stays 1 across the boundary.
REQ-021 No handshake during the last-bit cycle: state shall return to IDLE after that cycle.
REQ-022 In IDLE, sdo, sdo_valid, sdo_first, sdo_last shall all be 0.
REQ-023 Changes on din after the handshake shall not affect the frame in progress.
REQ-024 All outputs except din_ready shall be driven directly from registers.

Reset
REQ-025 reset_n=0 shall, without waiting for clk, force state to IDLE, clear the shift register and bit counter, and drive sdo=0, sdo_valid=0, sdo_first=0, sdo_last=0, din_ready=1.
REQ-026 Reset asserted mid-frame shall abort the frame; remaining bits shall never be sent, and no sdo_last pulse shall occur.
REQ-027 After reset_n deasserts, the first rising edge with din_valid=1 shall be accepted as a normal handshake.

Verification
REQ-028 Reset: reset_n=0 with random din/din_valid -> all serial outputs 0 and din_ready=1, with and without clk running.
REQ-029 Single frame, WIDTH=8, MSB_FIRST=1, din=8'hA5 -> sdo=1,0,1,0,0,1,0,1 on 8 consecutive cycles, sdo_first on bit 0, sdo_last on bit 7, then IDLE.
REQ-030 Back-to-back: 8'hA5, then 8'h3C offered with din_valid held -> 16 contiguous valid bits 10100101 00111100, din_ready high only at idle and in the two last-bit cycles.
REQ-031 Busy stall: din_valid=1 with din=8'hFF during bits 1..6 of a frame -> ignored; 8'hFF sent only after the last-bit handshake; din changes mid-frame do not corrupt current bits.
REQ-032 MSB_FIRST=0, din=8'h01 -> sdo=1,0,0,0,0,0,0,0; WIDTH=1, din=1 -> one bit with sdo_first=sdo_last=1, din_ready=1 every cycle.
REQ-033 Reset mid-frame: reset_n=0 after bit 2 of 8'hA5 -> outputs 0 immediately, no sdo_last; after release, frame 8'h5A transmits 0,1,0,1,1,0,1,0 correctly.
